// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-wide RAM arbiter: FSM states, transfer sizes,
// requester ids and a helper that maps a size code to its last byte index.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbXfer,
    ArbTail,
    ArbDone
  } arb_state_t;

  typedef enum logic {
    ReqIf,
    ReqMem
  } req_id_t;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  // Size code 11 is treated as a full word.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      MemByte: last_index = 2'd0;
      MemHalf: last_index = 2'd1;
      default: last_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM port between instruction fetch and the MEM
// stage, sequencing 1/2/4-byte little-endian transfers one byte per cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  input  logic [7:0]            ram_din_i,
  output logic [7:0]            ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic                  ram_wr_o,
  output logic                  busy_o
);

  arb_state_t            state_q, state_d;
  req_id_t               req_q, req_d;
  logic                  we_q, we_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;

  logic                  if_done_d, mem_done_d, ram_wr_d, busy_d;
  logic [31:0]           if_inst_d, mem_rdata_d;
  logic [7:0]            ram_dout_d;
  logic [ADDR_WIDTH-1:0] ram_a_d;
  logic [1:0]            lane;
  logic [31:0]           assembled;
  logic                  flush_now;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    last_d      = last_q;
    k_d         = k_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_o;
    mem_rdata_d = mem_rdata_o;
    ram_a_d     = ram_a_o;
    ram_dout_d  = 8'h00;
    ram_wr_d    = 1'b0;
    busy_d      = busy_o;
    lane        = k_q - 2'd1;
    assembled   = rbuf_q;
    flush_now   = (req_q == ReqIf) && if_flush_i;

    case (state_q)
      ArbIdle: begin
        if (mem_req_i) begin
          req_d      = ReqMem;
          we_d       = mem_we_i;
          last_d     = last_index(mem_size_i);
          addr_d     = mem_addr_i;
          wdata_d    = mem_wdata_i;
          k_d        = 2'd0;
          rbuf_d     = '0;
          state_d    = ArbXfer;
          ram_a_d    = mem_addr_i;
          ram_wr_d   = mem_we_i;
          ram_dout_d = mem_we_i ? mem_wdata_i[7:0] : 8'h00;
          busy_d     = 1'b1;
        end else if (if_req_i && !if_flush_i) begin
          req_d    = ReqIf;
          we_d     = 1'b0;
          last_d   = 2'd3;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          k_d      = 2'd0;
          rbuf_d   = '0;
          state_d  = ArbXfer;
          ram_a_d  = if_addr_i;
          busy_d   = 1'b1;
        end
      end

      ArbXfer: begin
        if (flush_now) begin
          state_d = ArbIdle;
          busy_d  = 1'b0;
        end else begin
          // The byte addressed one cycle ago is on ram_din_i now.
          if (!we_q && (k_q != 2'd0)) begin
            rbuf_d[{lane, 3'b000} +: 8] = ram_din_i;
          end
          if (k_q == last_q) begin
            if (we_q) begin
              state_d    = ArbDone;
              mem_done_d = 1'b1;
            end else begin
              state_d = ArbTail;
            end
          end else begin
            k_d        = k_q + 2'd1;
            ram_a_d    = addr_q + ADDR_WIDTH'(k_d);
            ram_wr_d   = we_q;
            ram_dout_d = we_q ? wdata_q[{k_d, 3'b000} +: 8] : 8'h00;
          end
        end
      end

      ArbTail: begin
        if (flush_now) begin
          state_d = ArbIdle;
          busy_d  = 1'b0;
        end else begin
          assembled[{last_q, 3'b000} +: 8] = ram_din_i;
          state_d = ArbDone;
          if (req_q == ReqIf) begin
            if_done_d = 1'b1;
            if_inst_d = assembled;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = assembled;
          end
        end
      end

      ArbDone: begin
        state_d = ArbIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ArbIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      req_q       <= ReqIf;
      we_q        <= 1'b0;
      last_q      <= 2'd0;
      k_q         <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_done_o   <= 1'b0;
      if_inst_o   <= '0;
      mem_done_o  <= 1'b0;
      mem_rdata_o <= '0;
      ram_dout_o  <= '0;
      ram_a_o     <= '0;
      ram_wr_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      last_q      <= last_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_done_o   <= if_done_d;
      if_inst_o   <= if_inst_d;
      mem_done_o  <= mem_done_d;
      mem_rdata_o <= mem_rdata_d;
      ram_dout_o  <= ram_dout_d;
      ram_a_o     <= ram_a_d;
      ram_wr_o    <= ram_wr_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected writes and done
// pulses with their cycle numbers; a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cycle;
    bit          check_data;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cycle;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_inst_o;
  logic        mem_req_i, mem_we_i, mem_done_o;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [7:0]  ram_din_i, ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  done_t if_q[$];
  done_t mem_q[$];
  wr_t   wr_q[$];

  logic [7:0] ram [0:1023];
  logic       tb_we = 1'b0;
  logic [9:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o),
    .ram_wr_o(ram_wr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (ram_wr_o === 1'b1) ram[ram_a_o[9:0]] <= ram_dout_o;
    else if (tb_we) ram[tb_addr] <= tb_data;
    ram_din_i <= ram[ram_a_o[9:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_done"}, 32'(if_done_o), 32'd0);
    checkOutput({tag, "_if_inst"}, if_inst_o, 32'd0);
    checkOutput({tag, "_mem_done"}, 32'(mem_done_o), 32'd0);
    checkOutput({tag, "_mem_rdata"}, mem_rdata_o, 32'd0);
    checkOutput({tag, "_ram_dout"}, {24'd0, ram_dout_o}, 32'd0);
    checkOutput({tag, "_ram_a"}, ram_a_o, 32'd0);
    checkOutput({tag, "_ram_wr"}, 32'(ram_wr_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic ramPoke(input logic [9:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cycle = c;
    wr_q.push_back(w);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Raise one request now; the grant happens at cycle cyc+delay.
  task automatic applyStimulus(input bit is_if, input bit we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_data, input int delay,
                               output int done_cyc);
    int    c;
    int    n;
    done_t d;
    c = cyc + delay;
    n = (size == MemByte) ? 1 : (size == MemHalf) ? 2 : 4;
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size;
      mem_addr_i = addr; mem_wdata_i = wdata;
    end
    if (we) for (int k = 0; k < n; k++) expectWrite(addr + 32'(k), wdata[8*k +: 8], c + 1 + k);
    d.data = exp_data;
    d.check_data = !we;
    d.cycle = we ? c + n + 1 : c + n + 2;
    if (is_if) if_q.push_back(d);
    else mem_q.push_back(d);
    done_cyc = d.cycle;
  endtask

  // Monitor: every done pulse and RAM write must match the head of its queue.
  done_t me;
  wr_t   mw;
  always @(negedge clk) begin
    if (if_done_o === 1'b1) begin
      if (if_q.size() == 0) checkOutput("if_done_unexpected", 32'd1, 32'd0);
      else begin
        me = if_q.pop_front();
        checkOutput("if_done_cycle", cyc, me.cycle);
        checkOutput("if_inst", if_inst_o, me.data);
      end
    end
    if (mem_done_o === 1'b1) begin
      if (mem_q.size() == 0) checkOutput("mem_done_unexpected", 32'd1, 32'd0);
      else begin
        me = mem_q.pop_front();
        checkOutput("mem_done_cycle", cyc, me.cycle);
        if (me.check_data) checkOutput("mem_rdata", mem_rdata_o, me.data);
      end
    end
    if (ram_wr_o === 1'b1) begin
      if (wr_q.size() == 0) checkOutput("ram_wr_unexpected", 32'd1, 32'd0);
      else begin
        mw = wr_q.pop_front();
        checkOutput("wr_cycle", cyc, mw.cycle);
        checkOutput("wr_addr", ram_a_o, mw.addr);
        checkOutput("wr_data", {24'd0, ram_dout_o}, {24'd0, mw.data});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int dc;
    int dc2;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = MemByte;
    mem_addr_i = '0; mem_wdata_i = '0;
    repeat (2) @(negedge clk);

    ramPoke(10'h100, 8'h13); ramPoke(10'h101, 8'h05); ramPoke(10'h102, 8'h00); ramPoke(10'h103, 8'h00);
    ramPoke(10'h041, 8'h34); ramPoke(10'h042, 8'h12);
    ramPoke(10'h080, 8'h78); ramPoke(10'h081, 8'h56); ramPoke(10'h082, 8'h34); ramPoke(10'h083, 8'h12);
    ramPoke(10'h104, 8'h93); ramPoke(10'h105, 8'h00); ramPoke(10'h106, 8'h10); ramPoke(10'h107, 8'h00);
    ramPoke(10'h200, 8'hB7); ramPoke(10'h201, 8'h12); ramPoke(10'h202, 8'h00); ramPoke(10'h203, 8'h00);
    ramPoke(10'h3FE, 8'h11); ramPoke(10'h3FF, 8'h22); ramPoke(10'h000, 8'h33); ramPoke(10'h001, 8'h44);
    ramPoke(10'h300, 8'hFF); ramPoke(10'h301, 8'hFF); ramPoke(10'h302, 8'hFF); ramPoke(10'h303, 8'h00);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Instruction fetch: address walk 0x100..0x103, done six cycles after grant.
    c = cyc;
    applyStimulus(1'b1, 1'b0, MemWord, 32'h100, 32'h0, 32'h0000_0513, 0, dc);
    @(negedge clk);
    if_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      waitUntil(c + 1 + k);
      checkOutput("if_addr_walk", ram_a_o, 32'h100 + 32'(k));
      checkOutput("if_read_no_wr", 32'(ram_wr_o), 32'd0);
    end
    waitUntil(dc + 1);

    // Word store, then read it back.
    applyStimulus(1'b0, 1'b1, MemWord, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, dc);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(dc);
    checkOutput("store_done_wr_low", 32'(ram_wr_o), 32'd0);
    checkOutput("store_done_dout_zero", {24'd0, ram_dout_o}, 32'd0);
    waitUntil(dc + 1);
    applyStimulus(1'b0, 1'b0, MemWord, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, dc);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(dc + 1);

    // Half and byte loads.
    applyStimulus(1'b0, 1'b0, MemHalf, 32'h41, 32'h0, 32'h0000_1234, 0, dc);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(dc + 1);
    applyStimulus(1'b0, 1'b0, MemByte, 32'h42, 32'h0, 32'h0000_0012, 0, dc);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(dc + 1);

    // Simultaneous requests: MEM word load first, IF granted at C+7.
    c = cyc;
    applyStimulus(1'b0, 1'b0, MemWord, 32'h80, 32'h0, 32'h1234_5678, 0, dc);
    applyStimulus(1'b1, 1'b0, MemWord, 32'h104, 32'h0, 32'h0010_0093, 7, dc2);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(c + 7);
    checkOutput("arb_gap_busy", 32'(busy_o), 32'd0);
    waitUntil(c + 8);
    checkOutput("if_after_mem_busy", 32'(busy_o), 32'd1);
    checkOutput("if_after_mem_addr", ram_a_o, 32'h104);
    if_req_i = 1'b0;
    waitUntil(dc2 + 1);

    // Flush in C+3 aborts the fetch; a new fetch then completes.
    c = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h108;
    @(negedge clk);
    if_req_i = 1'b0;
    waitUntil(c + 3);
    if_flush_i = 1'b1;
    @(negedge clk);
    if_flush_i = 1'b0;
    checkOutput("flush_busy", 32'(busy_o), 32'd0);
    checkOutput("flush_ram_wr", 32'(ram_wr_o), 32'd0);
    checkOutput("flush_if_done", 32'(if_done_o), 32'd0);
    checkOutput("flush_if_inst_kept", if_inst_o, 32'h0010_0093);
    applyStimulus(1'b1, 1'b0, MemWord, 32'h200, 32'h0, 32'h0000_12B7, 0, dc);
    @(negedge clk);
    if_req_i = 1'b0;
    waitUntil(dc + 2);
    checkOutput("flush_no_late_done", 32'(if_done_o), 32'd0);

    // Address wrap with size code 11.
    c = cyc;
    applyStimulus(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211, 0, dc);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(c + 2);
    checkOutput("wrap_addr_ff", ram_a_o, 32'hFFFF_FFFF);
    waitUntil(c + 3);
    checkOutput("wrap_addr_0", ram_a_o, 32'h0);
    waitUntil(dc + 1);

    // Reset while byte 2 of a store is on the bus.
    c = cyc;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = MemWord;
    mem_addr_i = 32'h300; mem_wdata_i = 32'h1122_3344;
    expectWrite(32'h300, 8'h44, c + 1);
    expectWrite(32'h301, 8'h33, c + 2);
    expectWrite(32'h302, 8'h22, c + 3);
    @(negedge clk);
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    waitUntil(c + 3);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, MemWord, 32'h300, 32'h0, 32'h0022_3344, 0, dc);
    @(negedge clk);
    mem_req_i = 1'b0;
    waitUntil(dc + 3);

    checkOutput("if_queue_drained", 32'(if_q.size()), 32'd0);
    checkOutput("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
